// File: rtl/synch_fifo_drain.sv
// -----------------------------------------------------------------------------
// synch_fifo_drain
//
// Read-side controller for the 8-bit synchronous FIFO. Pulls words from the
// FIFO read port into a 3-entry skid buffer and presents them on a downstream
// valid/ready stream at up to one word per cycle. A read is only issued when
// the FIFO is non-empty and the buffer is guaranteed to have a free slot for
// the word when it arrives one cycle later, so no overflow is possible.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   en          read enable; low stops new FIFO reads (buffer still drains)
//   flush       synchronous discard of buffered and in-flight words
//   fifo_empty  registered FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after fifo_rd
//   fifo_rd     FIFO read strobe
//   m_valid     downstream word available
//   m_ready     downstream accepts the word
//   m_data      downstream word
//   word_cnt    count of accepted words (wraps)
//   idle        buffer empty and no read in flight
// -----------------------------------------------------------------------------
module synch_fifo_drain #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] word_cnt,
    output logic          idle
);

    logic [DW-1:0] buf_mem [0:2];
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [1:0]    cnt;
    logic          pend;
    logic [2:0]    fill;
    logic          push;
    logic          pop;

    // Pointers walk 0 -> 1 -> 2 -> 0 over the 3 buffer slots.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words held plus the word already requested from the FIFO. A new read is
    // only safe while this leaves a slot free for the returning word. Only
    // registered state feeds this, so m_ready never reaches fifo_rd.
    assign fill    = {1'b0, cnt} + {2'b00, pend};
    assign fifo_rd = en && !fifo_empty && !flush && (fill <= 3'd2);

    assign m_valid = (cnt != 2'd0);
    assign m_data  = buf_mem[head];
    assign idle    = (cnt == 2'd0) && !pend;

    // A flush overrides both capture and pop; a pop in the flush cycle is
    // neither consumed nor counted.
    assign push = pend && !flush;
    assign pop  = m_valid && m_ready && !flush;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let cnt/pointer updates
    // race each other within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is only three words, and clearing it is what
            // makes m_data read 0 out of reset; a deep memory would not be
            // reset, since its contents are never observed before being written.
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            word_cnt <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            pend <= fifo_rd;

            if (push) begin
                buf_mem[tail] <= fifo_data;
                tail          <= next_ptr(tail);
            end

            if (pop) begin
                head     <= next_ptr(head);
                word_cnt <= word_cnt + CW'(1);
            end

            // Simultaneous capture and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule
